hw_frame_latch: RTL and testbench
=================================

// Module: hw_frame_latch
// PURPOSE
//  Downstream consumer of the NIOS to_hw_port0..9 PIO exports. Captures the ten 32-bit
//  object words on a to_hw_sig handshake, acknowledges on to_sw_sig, and holds them in
//  a staging bank. Commits staging to the active bank only at frame_start (vsync), so
//  the sprite/draw logic never sees a half-updated object set (no tearing).
// PARAMETERS
//  NUM_PORTS  10  number of 32-bit object words captured per frame
//  DATA_W     32  width of each object word
//  CNT_W      16  width of stats counters (FRAME_LATCH_STATS_EN only)
// PORTS
//  Clk          in   1                   system clock, single domain
//  Reset        in   1                   synchronous, active-high
//  port_data    in   NUM_PORTS*DATA_W    to_hw_port0..9 concatenated, port0 in [DATA_W-1:0]
//  to_hw_sig    in   2                   SW command: 00 idle, 01 load, 10 clear, 11 reserved
//  frame_start  in   1                   one-cycle pulse at start of vertical blank
//  to_sw_sig    out  2                   ack to SW: 00 idle, 01 load ack, 10 clear ack
//  obj_data     out  NUM_PORTS*DATA_W    active bank, stable between frame_start pulses
//  frame_valid  out  1                   high once any commit has occurred since reset
//  pending      out  1                   staging holds data not yet committed
//  frame_count  out  CNT_W               commits since reset (stats build only)
//  drop_count   out  CNT_W               staged sets overwritten before commit (stats only)
// BEHAVIOUR
//  - One clock, Reset synchronous active-high. Reset: state=IDLE, staging=0, obj_data=0,
//    to_sw_sig=00, frame_valid=0, pending=0, counters=0. Reset mid-handshake aborts it.
//  - FSM IDLE: to_sw_sig=00. to_hw_sig==01 -> staging<=port_data, pending<=1, go ACK_LOAD.
//    to_hw_sig==10 -> staging<=0, pending<=1, go ACK_CLR. 00/11 -> stay.
//  - ACK_LOAD: to_sw_sig=01; ACK_CLR: to_sw_sig=10. Both hold until to_hw_sig==00, then IDLE.
//    Any other to_hw_sig value while acking is ignored (no recapture).
//  - Latency: command sampled at edge N -> staging and to_sw_sig updated at edge N
//    (registered; visible in cycle after N). Return to 00 one edge after SW releases.
//  - Commit: at any edge with frame_start && pending: obj_data<=staging, pending<=0,
//    frame_valid<=1, frame_count++. frame_start with !pending: no change.
//  - Capture while pending=1 (not yet committed): staging overwritten (latest wins),
//    drop_count++.
//  - Same-edge capture and frame_start: commit uses staging value before the edge; the
//    new capture lands in staging and pending stays 1; not counted as a drop.
//  - Counters saturate at all-ones; no wrap.
// CONFIGURATION
//  FRAME_LATCH_STATS_EN defined: frame_count/drop_count implemented as above.
//  Not defined: both ports tied to 0, counter registers removed; all other behaviour
//  identical.
// TESTING
//  1 Reset held 3 cycles with to_hw_sig=01 -> to_sw_sig=00, obj_data=0, pending=0.
//  2 port_data words k=0x1000+k, to_hw_sig=01 -> next cycle to_sw_sig=01, pending=1,
//    obj_data still 0; frame_start pulse -> obj_data word3=0x1003, frame_valid=1.
//  3 Load A, release to 00, load B before frame_start -> drop_count=1; commit shows B.
//  4 to_hw_sig=01 captured on same edge as frame_start with pending A -> obj_data=A,
//    staging=new, pending=1, drop_count unchanged; next frame_start -> new data.
//  5 Committed data, then to_hw_sig=10 -> to_sw_sig=10; obj_data unchanged until
//    frame_start, then all zero; to_hw_sig=11 in IDLE -> no state change.
//  6 Reset asserted in ACK_LOAD -> IDLE, to_sw_sig=00, pending=0 next cycle.

Source files
------------

// File: rtl/hw_frame_latch.sv
// rtl/hw_frame_latch.sv - double-buffered object word latch with SW handshake, optional FRAME_LATCH_STATS_EN counters
module hw_frame_latch #(
    parameter int NUM_PORTS = 10,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [NUM_PORTS*DATA_W-1:0] port_data,
    input  logic [1:0]                  to_hw_sig,
    input  logic                        frame_start,
    output logic [1:0]                  to_sw_sig,
    output logic [NUM_PORTS*DATA_W-1:0] obj_data,
    output logic                        frame_valid,
    output logic                        pending,
    output logic [CNT_W-1:0]            frame_count,
    output logic [CNT_W-1:0]            drop_count
);

    localparam int BANK_W = NUM_PORTS * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK_LOAD = 2'd1,
        ST_ACK_CLR  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BANK_W-1:0]   staging_q, staging_d;
    logic [BANK_W-1:0]   active_q, active_d;
    logic                pending_q, pending_d;
    logic                valid_q, valid_d;
    logic                capture;
    logic                commit;
    logic                drop;

    // Handshake FSM next state, ack encoding and capture decode
    always_comb begin
        state_d   = state_q;
        to_sw_sig = 2'b00;
        capture   = 1'b0;
        staging_d = staging_q;
        case (state_q)
            ST_IDLE: begin
                if (to_hw_sig == 2'b01) begin
                    capture   = 1'b1;
                    staging_d = port_data;
                    state_d   = ST_ACK_LOAD;
                end else if (to_hw_sig == 2'b10) begin
                    capture   = 1'b1;
                    staging_d = '0;
                    state_d   = ST_ACK_CLR;
                end
            end
            ST_ACK_LOAD: begin
                to_sw_sig = 2'b01;
                if (to_hw_sig == 2'b00) state_d = ST_IDLE;
            end
            ST_ACK_CLR: begin
                to_sw_sig = 2'b10;
                if (to_hw_sig == 2'b00) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Commit staging to the active bank at vsync; a same-edge capture keeps pending set
    always_comb begin
        commit    = frame_start && pending_q;
        drop      = capture && pending_q && !frame_start;
        active_d  = commit ? staging_q : active_q;
        valid_d   = valid_q | commit;
        pending_d = pending_q;
        if (capture) begin
            pending_d = 1'b1;
        end else if (commit) begin
            pending_d = 1'b0;
        end
    end

    // Core state registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            staging_q <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            staging_q <= staging_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
        end
    end

    assign obj_data    = active_q;
    assign frame_valid = valid_q;
    assign pending     = pending_q;

`ifdef FRAME_LATCH_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] frame_count_q, frame_count_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;

    // Saturating commit and overwrite counters
    always_comb begin
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;
        if (commit && (frame_count_q != '1)) frame_count_d = frame_count_q + CNT_ONE;
        if (drop && (drop_count_q != '1))    drop_count_d  = drop_count_q + CNT_ONE;
    end

    // Counter registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;
`else
    logic unused_stats;
    assign unused_stats = drop;
    assign frame_count  = '0;
    assign drop_count   = '0;
`endif

endmodule

// File: tb/tb_hw_frame_latch.sv
// tb/tb_hw_frame_latch.sv - randomized self-checking bench for hw_frame_latch
module tb_hw_frame_latch;

    localparam int NP    = 10;
    localparam int DW    = 32;
    localparam int CW    = 4;
    localparam int BW    = NP * DW;
    localparam int CMAX  = (1 << CW) - 1;
`ifdef FRAME_LATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [BW-1:0] port_data = '0;
    logic [1:0]    to_hw_sig = 2'b00;
    logic          frame_start = 1'b0;
    logic [1:0]    to_sw_sig;
    logic [BW-1:0] obj_data;
    logic          frame_valid;
    logic          pending;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] drop_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [BW-1:0] m_stg, m_obj;
    bit            m_pend, m_fv;
    int            m_ack, m_fc, m_dc;
    logic [CW-1:0] exp_fc, exp_dc;

    hw_frame_latch #(.NUM_PORTS(NP), .DATA_W(DW), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset), .port_data(port_data), .to_hw_sig(to_hw_sig),
        .frame_start(frame_start), .to_sw_sig(to_sw_sig), .obj_data(obj_data),
        .frame_valid(frame_valid), .pending(pending), .frame_count(frame_count),
        .drop_count(drop_count)
    );

    always #5 Clk = ~Clk;

    function automatic logic [BW-1:0] rand_bank();
        logic [BW-1:0] v;
        for (int k = 0; k < NP; k++) v[k*DW +: DW] = $urandom;
        return v;
    endfunction

    task automatic model_edge(input bit rst, input logic [1:0] cmd, input bit fs,
                              input logic [BW-1:0] d);
        bit cap;
        if (rst) begin
            m_stg = '0; m_obj = '0; m_pend = 0; m_fv = 0; m_ack = 0; m_fc = 0; m_dc = 0;
        end else begin
            cap = (m_ack == 0) && (cmd == 2'b01 || cmd == 2'b10);
            if (fs && m_pend) begin
                m_obj = m_stg;
                m_fv  = 1;
                if (m_fc < CMAX) m_fc++;
            end
            if (cap) begin
                if (m_pend && !fs && m_dc < CMAX) m_dc++;
                m_stg  = (cmd == 2'b01) ? d : '0;
                m_pend = 1;
                m_ack  = int'(cmd);
            end else begin
                if (fs) m_pend = 0;
                if (m_ack != 0 && cmd == 2'b00) m_ack = 0;
            end
        end
        exp_fc = STATS ? CW'(m_fc) : '0;
        exp_dc = STATS ? CW'(m_dc) : '0;
    endtask

    task automatic cycle(input bit rst, input logic [1:0] cmd, input bit fs,
                         input logic [BW-1:0] d);
        Reset = rst; to_hw_sig = cmd; frame_start = fs; port_data = d;
        @(posedge Clk);
        model_edge(rst, cmd, fs, d);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'b01, 1'b0, rand_bank());
        checks++; if (to_sw_sig !== 2'b00) begin errors++; $display("FAIL reset_to_sw got %b want 00", to_sw_sig); end
        checks++; if (obj_data !== '0) begin errors++; $display("FAIL reset_obj got %h want 0", obj_data); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", pending); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", frame_valid); end
        checks++; if (frame_count !== '0 || drop_count !== '0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", frame_count, drop_count); end
        cycle(1'b0, 2'b00, 1'b0, '0);
    endtask

    task automatic test_load_commit();
        logic [BW-1:0] d;
        for (int k = 0; k < NP; k++) d[k*DW +: DW] = 32'h1000 + k;
        cycle(1'b0, 2'b01, 1'b0, d);
        checks++; if (to_sw_sig !== 2'b01) begin errors++; $display("FAIL load_ack got %b want 01", to_sw_sig); end
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL load_pending got %b want 1", pending); end
        checks++; if (obj_data !== '0) begin errors++; $display("FAIL load_obj_early got %h want 0", obj_data); end
        cycle(1'b0, 2'b00, 1'b0, '0);
        checks++; if (to_sw_sig !== 2'b00) begin errors++; $display("FAIL load_release got %b want 00", to_sw_sig); end
        cycle(1'b0, 2'b00, 1'b1, '0);
        checks++; if (obj_data[3*DW +: DW] !== 32'h1003) begin errors++; $display("FAIL commit_word3 got %h want 00001003", obj_data[3*DW +: DW]); end
        checks++; if (obj_data !== d) begin errors++; $display("FAIL commit_bank got %h want %h", obj_data, d); end
        checks++; if (frame_valid !== 1'b1 || pending !== 1'b0) begin errors++; $display("FAIL commit_flags got v=%b p=%b want v=1 p=0", frame_valid, pending); end
        checks++; if (frame_count !== exp_fc) begin errors++; $display("FAIL commit_count got %0d want %0d", frame_count, exp_fc); end
    endtask

    task automatic test_drop();
        logic [BW-1:0] a, b;
        a = rand_bank(); b = rand_bank();
        cycle(1'b0, 2'b01, 1'b0, a);
        cycle(1'b0, 2'b00, 1'b0, '0);
        cycle(1'b0, 2'b01, 1'b0, b);
        checks++; if (drop_count !== (STATS ? CW'(1) : CW'(0))) begin errors++; $display("FAIL drop_count got %0d want %0d", drop_count, STATS ? 1 : 0); end
        cycle(1'b0, 2'b00, 1'b0, '0);
        cycle(1'b0, 2'b00, 1'b1, '0);
        checks++; if (obj_data !== b) begin errors++; $display("FAIL drop_latest got %h want %h", obj_data, b); end
    endtask

    task automatic test_same_edge();
        logic [BW-1:0] a, c;
        logic [CW-1:0] dc0;
        a = rand_bank(); c = rand_bank();
        cycle(1'b0, 2'b01, 1'b0, a);
        cycle(1'b0, 2'b00, 1'b0, '0);
        dc0 = drop_count;
        cycle(1'b0, 2'b01, 1'b1, c);
        checks++; if (obj_data !== a) begin errors++; $display("FAIL same_edge_obj got %h want %h", obj_data, a); end
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL same_edge_pending got %b want 1", pending); end
        checks++; if (drop_count !== dc0) begin errors++; $display("FAIL same_edge_drop got %0d want %0d", drop_count, dc0); end
        cycle(1'b0, 2'b00, 1'b0, '0);
        cycle(1'b0, 2'b00, 1'b1, '0);
        checks++; if (obj_data !== c) begin errors++; $display("FAIL same_edge_next got %h want %h", obj_data, c); end
    endtask

    task automatic test_clear();
        logic [BW-1:0] held;
        held = obj_data;
        cycle(1'b0, 2'b10, 1'b0, rand_bank());
        checks++; if (to_sw_sig !== 2'b10) begin errors++; $display("FAIL clear_ack got %b want 10", to_sw_sig); end
        checks++; if (obj_data !== held || held === '0) begin errors++; $display("FAIL clear_hold got %h want %h", obj_data, held); end
        cycle(1'b0, 2'b00, 1'b0, '0);
        cycle(1'b0, 2'b11, 1'b0, rand_bank());
        cycle(1'b0, 2'b11, 1'b0, rand_bank());
        checks++; if (to_sw_sig !== 2'b00 || pending !== 1'b1) begin errors++; $display("FAIL reserved_cmd got ack=%b p=%b want ack=00 p=1", to_sw_sig, pending); end
        cycle(1'b0, 2'b00, 1'b1, '0);
        checks++; if (obj_data !== '0) begin errors++; $display("FAIL clear_commit got %h want 0", obj_data); end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 2'b01, 1'b0, rand_bank());
        checks++; if (to_sw_sig !== 2'b01) begin errors++; $display("FAIL mid_ack got %b want 01", to_sw_sig); end
        cycle(1'b1, 2'b01, 1'b0, rand_bank());
        checks++; if (to_sw_sig !== 2'b00 || pending !== 1'b0) begin errors++; $display("FAIL mid_reset got ack=%b p=%b want ack=00 p=0", to_sw_sig, pending); end
        cycle(1'b0, 2'b00, 1'b0, '0);
    endtask

    task automatic test_random();
        logic [1:0] cmd;
        int r;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            cmd = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            cycle(i == 300, cmd, $urandom_range(0, 5) == 0, rand_bank());
            checks++;
            if (to_sw_sig !== 2'(m_ack) || pending !== m_pend || frame_valid !== m_fv ||
                obj_data !== m_obj || frame_count !== exp_fc || drop_count !== exp_dc) begin
                errors++;
                $display("FAIL random_cycle%0d got ack=%b p=%b v=%b fc=%0d dc=%0d obj_ok=%b want ack=%0d p=%b v=%b fc=%0d dc=%0d",
                         i, to_sw_sig, pending, frame_valid, frame_count, drop_count,
                         obj_data === m_obj, m_ack, m_pend, m_fv, exp_fc, exp_dc);
            end
        end
        checks++;
        if (STATS && (frame_count !== CW'(CMAX) || drop_count !== CW'(CMAX))) begin
            errors++;
            $display("FAIL saturate got fc=%0d dc=%0d want %0d", frame_count, drop_count, CMAX);
        end
    endtask

    initial begin
        test_reset();
        test_load_commit();
        test_drop();
        test_same_edge();
        test_clear();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
